// File: rtl/bash_hash_params_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bash_hash_params_pkg
// Brief   : Shared constants, state type and round-constant helper for Bash-F.
// Revision: 1.0
// ============================================================================
package bash_hash_params_pkg;

    localparam int SLEN          = 64;
    localparam int BASH_F_ROUNDS = 24;
    localparam int BASH_F_WORDS  = 24;
    localparam int BASH_STATE_W  = BASH_F_WORDS * SLEN;

    localparam logic [63:0] BASH_F_INIT  = 64'hB194_BAC8_0A08_F53B;
    localparam logic [63:0] BASH_F_CONST = 64'hAED8_E07F_99E1_2BDC;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Word k occupies bits [64k+63:64k] of the flat state vector.
    typedef logic [BASH_F_WORDS-1:0][SLEN-1:0] bash_state_t;

    localparam int M1_BASH_S [0:7] = '{8, 56, 8, 56, 8, 56, 8, 56};
    localparam int N1_BASH_S [0:7] = '{53, 51, 37, 3, 21, 19, 5, 35};
    localparam int M2_BASH_S [0:7] = '{14, 34, 46, 2, 14, 34, 46, 2};
    localparam int N2_BASH_S [0:7] = '{1, 7, 49, 23, 33, 39, 17, 55};

    localparam int P_BASH_F [0:23] = '{15, 10,  9, 12, 11, 14, 13,  8,
                                       17, 16, 19, 18, 21, 20, 23, 22,
                                        6,  3,  0,  5,  2,  7,  4,  1};

    // Galois-LFSR step producing the next round constant.
    function automatic logic [63:0] bash_f_next_c(input logic [63:0] c);
        return c[0] ? ((c >> 1) ^ BASH_F_CONST) : (c >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bash_s.sv
`default_nettype none
// ============================================================================
// Module  : bash_s
// Brief   : Combinational Bash-S column mixer with fixed rotation amounts.
// Revision: 1.0
// ============================================================================
module bash_s #(
    parameter int M1 = 8,
    parameter int N1 = 53,
    parameter int M2 = 14,
    parameter int N2 = 1
) (
    input  logic [63:0] w0_i,
    input  logic [63:0] w1_i,
    input  logic [63:0] w2_i,
    output logic [63:0] w0_o,
    output logic [63:0] w1_o,
    output logic [63:0] w2_o
);

    function automatic logic [63:0] rot_hi(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    logic [63:0] t0;
    logic [63:0] s0;
    logic [63:0] t1;
    logic [63:0] s1;
    logic [63:0] s2;

    assign t0 = rot_hi(w0_i, M1);
    assign s0 = w0_i ^ w1_i ^ w2_i;
    assign t1 = w1_i ^ rot_hi(s0, N1);
    assign s1 = t0 ^ t1;
    assign s2 = w2_i ^ rot_hi(w2_i, M2) ^ rot_hi(t1, N2);

    assign w0_o = s0 ^ (~s2 | s1);
    assign w1_o = s1 ^ (s0 | s2);
    assign w2_o = s2 ^ (s0 & s1);

endmodule
`default_nettype wire

// File: rtl/bash_f_core.sv
`default_nettype none
// ============================================================================
// Module  : bash_f_core
// Brief   : Iterative 24-round Bash-F permutation, ROUNDS_PER_CYCLE rounds/clk.
// Revision: 1.0
// ============================================================================
module bash_f_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int SLEN             = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [1535:0] state_i,
    input  logic          abort_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [1535:0] state_o,
    output logic          busy_o
);
    import bash_hash_params_pkg::*;

    if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > BASH_F_ROUNDS ||
        (BASH_F_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rounds
        $error("bash_f_core: ROUNDS_PER_CYCLE must divide 24");
    end
    if (SLEN != 64 || BASH_STATE_W != 1536) begin : g_bad_slen
        $error("bash_f_core: SLEN must be 64");
    end

    localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] CNT_LAST = 5'(BASH_F_ROUNDS - ROUNDS_PER_CYCLE);

    bash_state_t state_q, state_d;
    logic [63:0] c_q, c_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  fsm_q, fsm_d;

    bash_state_t round_s;
    logic [63:0] round_c;

    // Each stage is one full round; stages are chained combinationally.
    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
        bash_state_t s_in, mixed, s_out;
        logic [63:0] c_in, c_out;

        if (r == 0) begin : g_first
            assign s_in = state_q;
            assign c_in = c_q;
        end else begin : g_next
            assign s_in = g_round[r-1].s_out;
            assign c_in = g_round[r-1].c_out;
        end

        for (genvar j = 0; j < 8; j++) begin : g_col
            bash_s #(
                .M1(M1_BASH_S[j]),
                .N1(N1_BASH_S[j]),
                .M2(M2_BASH_S[j]),
                .N2(N2_BASH_S[j])
            ) u_bash_s (
                .w0_i(s_in[j]),
                .w1_i(s_in[8+j]),
                .w2_i(s_in[16+j]),
                .w0_o(mixed[j]),
                .w1_o(mixed[8+j]),
                .w2_o(mixed[16+j])
            );
        end

        for (genvar k = 0; k < 24; k++) begin : g_perm
            if (k == 23) begin : g_inject
                assign s_out[k] = mixed[P_BASH_F[k]] ^ c_in;
            end else begin : g_plain
                assign s_out[k] = mixed[P_BASH_F[k]];
            end
        end

        assign c_out = bash_f_next_c(c_in);
    end

    assign round_s = g_round[ROUNDS_PER_CYCLE-1].s_out;
    assign round_c = g_round[ROUNDS_PER_CYCLE-1].c_out;

    assign in_ready_o  = (fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & out_ready_i);
    assign out_valid_o = (fsm_q == ST_DONE);
    assign busy_o      = (fsm_q == ST_RUN);
    assign state_o     = state_q;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        if (abort_i) begin
            fsm_d = ST_IDLE;
            cnt_d = '0;
        end else begin
            case (fsm_q)
                ST_IDLE: ;
                ST_RUN: begin
                    state_d = round_s;
                    c_d     = round_c;
                    cnt_d   = cnt_q + CNT_STEP;
                    if (cnt_q == CNT_LAST) fsm_d = ST_DONE;
                end
                ST_DONE: if (out_ready_i) fsm_d = ST_IDLE;
                default: fsm_d = ST_IDLE;
            endcase
            // A load in DONE overrides the return to IDLE (back-to-back jobs).
            if (in_valid_i && in_ready_o) begin
                fsm_d   = ST_RUN;
                state_d = state_i;
                c_d     = BASH_F_INIT;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            c_q     <= BASH_F_INIT;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bash_f_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_bash_f_core
// Brief   : Scoreboard bench for bash_f_core with a loop-based Bash-F model.
// Revision: 1.0
// ============================================================================
module tb_bash_f_core;

    typedef logic [23:0][63:0] tstate_t;
    typedef struct {
        tstate_t st;
        int      acc;
    } exp_t;

    localparam int N_MAIN = 24;
    localparam logic [63:0] C_INIT = 64'hB194BAC80A08F53B;
    localparam logic [63:0] C_KEY  = 64'hAED8E07F99E12BDC;
    localparam int TM1 [8]  = '{8, 56, 8, 56, 8, 56, 8, 56};
    localparam int TN1 [8]  = '{53, 51, 37, 3, 21, 19, 5, 35};
    localparam int TM2 [8]  = '{14, 34, 46, 2, 14, 34, 46, 2};
    localparam int TN2 [8]  = '{1, 7, 49, 23, 33, 39, 17, 55};
    localparam int TP  [24] = '{15, 10, 9, 12, 11, 14, 13, 8, 17, 16, 19, 18,
                                21, 20, 23, 22, 6, 3, 0, 5, 2, 7, 4, 1};
    localparam int AUX_R [7] = '{2, 3, 4, 6, 8, 12, 24};

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    tstate_t       state_in;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [1535:0] state_out;
    logic          busy;

    int   cyc;
    int   total = 0;
    int   bad   = 0;
    int   rise_cyc;
    logic ov_prev;
    exp_t exp_q [$];

    logic    aux_valid;
    tstate_t aux_state;
    int      aux_acc;
    logic [7:0] aux_lat  [7];
    tstate_t    aux_got  [7];
    logic       aux_seen [7];
    logic       aux_busy [7];
    logic       aux_ir   [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bash_f_core #(.ROUNDS_PER_CYCLE(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .state_i(state_in), .abort_i(abort), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .state_o(state_out), .busy_o(busy)
    );

    for (genvar g = 0; g < 7; g++) begin : g_aux
        logic ov, ir, bz, prev_ov, seen, busy_at;
        logic [7:0]    lat;
        logic [1535:0] so;
        tstate_t       got;
        bash_f_core #(.ROUNDS_PER_CYCLE(AUX_R[g])) u_core (
            .clk_i(clk), .rst_ni(rst_n), .in_valid_i(aux_valid), .in_ready_o(ir),
            .state_i(aux_state), .abort_i(1'b0), .out_valid_o(ov),
            .out_ready_i(1'b1), .state_o(so), .busy_o(bz)
        );
        always @(negedge clk) begin
            if (!rst_n) begin
                prev_ov <= 1'b0;
                seen    <= 1'b0;
            end else begin
                prev_ov <= ov;
                if (ov && !prev_ov && !seen) begin
                    seen    <= 1'b1;
                    lat     <= 8'(cyc - aux_acc);
                    got     <= so;
                    busy_at <= bz;
                end
            end
        end
        assign aux_lat[g]  = lat;
        assign aux_got[g]  = got;
        assign aux_seen[g] = seen;
        assign aux_busy[g] = busy_at;
        assign aux_ir[g]   = ir;
    end

    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic tstate_t ref_bash_f(input tstate_t x);
        logic [63:0] s [24];
        logic [63:0] t [24];
        logic [63:0] c, w0, w1, w2, t0, t1, t2;
        tstate_t res;
        c = C_INIT;
        for (int i = 0; i < 24; i++) s[i] = x[i];
        for (int r = 0; r < 24; r++) begin
            for (int j = 0; j < 8; j++) begin
                w0 = s[j]; w1 = s[8+j]; w2 = s[16+j];
                t0 = rl(w0, TM1[j]);
                w0 = w0 ^ w1 ^ w2;
                t1 = w1 ^ rl(w0, TN1[j]);
                w1 = t0 ^ t1;
                w2 = w2 ^ rl(w2, TM2[j]) ^ rl(t1, TN2[j]);
                t0 = ~w2 | w1;
                t1 = w0 | w2;
                t2 = w0 & w1;
                w1 = w1 ^ t1; w2 = w2 ^ t2; w0 = w0 ^ t0;
                s[j] = w0; s[8+j] = w1; s[16+j] = w2;
            end
            for (int i = 0; i < 24; i++) t[i] = s[TP[i]];
            for (int i = 0; i < 24; i++) s[i] = t[i];
            s[23] = s[23] ^ c;
            c = c[0] ? ((c >> 1) ^ C_KEY) : (c >> 1);
        end
        for (int i = 0; i < 24; i++) res[i] = s[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, got, want);
        end
    endtask

    task automatic chk_state(input string name, input tstate_t got, input tstate_t want);
        int w = -1;
        total++;
        for (int i = 23; i >= 0; i--) if (got[i] !== want[i]) w = i;
        if (w >= 0) begin
            bad++;
            $display("FAIL %s: word %0d got=%h want=%h", name, w, got[w], want[w]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drives a job, waits for acceptance, optionally records its expected result.
    task automatic send(input tstate_t s, input bit push);
        int g = 0;
        in_valid = 1'b1;
        state_in = s;
        #1;
        while (!in_ready && g < 100) begin
            tick();
            #1;
            g++;
        end
        chk1("send_ready", in_ready, 1'b1);
        if (push) exp_q.push_back('{ref_bash_f(s), cyc + 1});
        tick();
        in_valid = 1'b0;
        state_in = ~s;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            tick();
            g++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !ov_prev) rise_cyc = cyc;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk1("unexpected_output", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk_state("result", state_out, e.st);
                    chk("latency", 64'(rise_cyc - e.acc), 64'(N_MAIN));
                end
            end
            ov_prev = rst_n ? out_valid : 1'b0;
        end
    endtask

    initial begin
        tstate_t va, vb, vc, vd, ve, snap;
        int guard;
        rst_n = 1'b0; in_valid = 1'b0; state_in = '0; abort = 1'b0; out_ready = 1'b1;
        aux_valid = 1'b0; aux_state = '0; aux_acc = 0; ov_prev = 1'b0; rise_cyc = 0;
        for (int k = 0; k < 24; k++) begin
            va[k] = 64'(k + 1) * 64'h0101_0101_0101_0101;
            vb[k] = {32'(k), ~32'(k)};
            vc[k] = 64'h0123_4567_89AB_CDEF ^ (64'(k) << (2 * k));
            vd[k] = {8{8'(17 * k)}};
            ve[k] = ~64'(k);
        end
        fork
            monitor();
        join_none

        repeat (3) tick();
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_c", u_dut.c_q, C_INIT);
        chk_state("rst_state", u_dut.state_q, '0);
        rst_n = 1'b1;
        repeat (50) tick();
        chk1("idle_in_ready", in_ready, 1'b1);
        chk1("idle_out_valid", out_valid, 1'b0);
        chk1("idle_busy", busy, 1'b0);

        // Job A with round-constant probe
        send(va, 1'b1);
        chk("c_at_load", u_dut.c_q, C_INIT);
        chk1("run_busy", busy, 1'b1);
        chk1("run_in_ready", in_ready, 1'b0);
        tick();
        chk("c_round1", u_dut.c_q, 64'hF612BD1B9CE55141);
        chk("cnt_round1", 64'(u_dut.cnt_q), 64'd1);
        wait_drain("drain_a");

        // Backpressure then back-to-back acceptance
        out_ready = 1'b0;
        send(vb, 1'b1);
        guard = 0;
        while (!out_valid && guard < 100) begin tick(); guard++; end
        chk1("bp_valid_reached", out_valid, 1'b1);
        snap = state_out;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("bp_valid_hold", out_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk_state("bp_state_hold", state_out, snap);
        end
        out_ready = 1'b1;
        send(vc, 1'b1);
        chk1("b2b_busy", busy, 1'b1);
        wait_drain("drain_bc");

        // Abort during RUN
        send(vd, 1'b0);
        repeat (4) tick();
        snap = u_dut.state_q;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk("abort_cnt", 64'(u_dut.cnt_q), 64'd0);
        chk_state("abort_state_kept", u_dut.state_q, snap);
        repeat (30) tick();
        chk1("abort_no_output", out_valid, 1'b0);
        send(ve, 1'b1);
        wait_drain("drain_e");

        // Asynchronous reset mid-RUN
        send(va, 1'b0);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk1("arst_in_ready", in_ready, 1'b1);
        chk1("arst_out_valid", out_valid, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk("arst_c", u_dut.c_q, C_INIT);
        chk_state("arst_state", u_dut.state_q, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk1("arst_no_output", out_valid, 1'b0);

        // Unrolled variants on a common input
        for (int g = 0; g < 7; g++) chk1("aux_ready", aux_ir[g], 1'b1);
        aux_valid = 1'b1;
        aux_state = vc;
        aux_acc   = cyc + 1;
        tick();
        aux_valid = 1'b0;
        repeat (30) tick();
        snap = ref_bash_f(vc);
        for (int g = 0; g < 7; g++) begin
            chk1("aux_seen", aux_seen[g], 1'b1);
            chk("aux_latency", 64'(aux_lat[g]), 64'(24 / AUX_R[g]));
            chk_state("aux_result", aux_got[g], snap);
            chk1("aux_busy_done", aux_busy[g], 1'b0);
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
